// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Issue-side initiator for the 36-bit ALU. Accepts one operation command at a
// time over a valid/ready channel, presents its operands and opcode to the ALU
// for a single EXEC cycle, samples the ALU's combinational result and returns
// it with the command tag over a valid/ready response channel. It also owns
// the architectural Z/N flags. Only SUBS updates them, and they are derived
// from the sampled result rather than from the ALU's own flag outputs.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_op/a/b/tag   command channel
//   o_alu_a/b/op          registered ALU operand/control inputs
//   i_alu_result          ALU combinational result
//   o_rsp_valid/i_rsp_ready, o_rsp_result/tag/err   response channel
//   o_flag_z, o_flag_n    architectural zero / negative flags
//   o_busy                high whenever the issuer is not idle
// -----------------------------------------------------------------------------
`ifndef ALU_ADD
`define ALU_ADD  3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB  3'd1
`endif
`ifndef ALU_SUBS
`define ALU_SUBS 3'd2
`endif
`ifndef ALU_AND
`define ALU_AND  3'd3
`endif
`ifndef ALU_OR
`define ALU_OR   3'd4
`endif

module alu_cmd_issuer #(
    parameter int DATA_WIDTH   = 36,
    parameter int ALU_OP_WIDTH = 3,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [ALU_OP_WIDTH-1:0] i_cmd_op,
    input  logic [DATA_WIDTH-1:0]   i_cmd_a,
    input  logic [DATA_WIDTH-1:0]   i_cmd_b,
    input  logic [TAG_WIDTH-1:0]    i_cmd_tag,
    output logic [DATA_WIDTH-1:0]   o_alu_a,
    output logic [DATA_WIDTH-1:0]   o_alu_b,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_result,
    output logic [TAG_WIDTH-1:0]    o_rsp_tag,
    output logic                    o_rsp_err,
    output logic                    o_flag_z,
    output logic                    o_flag_n,
    output logic                    o_busy
);

    localparam logic [ALU_OP_WIDTH-1:0] LP_OP_ADD  = `ALU_ADD;
    localparam logic [ALU_OP_WIDTH-1:0] LP_OP_SUB  = `ALU_SUB;
    localparam logic [ALU_OP_WIDTH-1:0] LP_OP_SUBS = `ALU_SUBS;
    localparam logic [ALU_OP_WIDTH-1:0] LP_OP_AND  = `ALU_AND;
    localparam logic [ALU_OP_WIDTH-1:0] LP_OP_OR   = `ALU_OR;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only the five ALU encodings may ever reach the ALU.
    function automatic logic op_is_legal(input logic [ALU_OP_WIDTH-1:0] op);
        logic legal;
        case (op)
            LP_OP_ADD, LP_OP_SUB, LP_OP_SUBS, LP_OP_AND, LP_OP_OR: legal = 1'b1;
            default:                                             legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t                  r_state;
    state_t                  w_state_base;
    state_t                  w_state_nxt;
    logic                    w_cmd_ready;
    logic                    w_accept;
    logic                    w_legal;

    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic [ALU_OP_WIDTH-1:0] r_alu_op;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_result;
    logic [TAG_WIDTH-1:0]    r_rsp_tag;
    logic                    r_rsp_err;
    logic                    r_flag_z;
    logic                    r_flag_n;
    logic                    r_busy;

    // Next-state and command-ready decode for the issue FSM.
    always_comb begin
        w_state_base = r_state;
        w_cmd_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready  = 1'b1;
                w_state_base = ST_IDLE;
            end
            ST_EXEC: begin
                w_cmd_ready  = 1'b0;
                w_state_base = ST_RESP;
            end
            ST_RESP: begin
                // A new command may only enter while the held response drains.
                w_cmd_ready  = i_rsp_ready;
                w_state_base = i_rsp_ready ? ST_IDLE : ST_RESP;
            end
            default: begin
                w_cmd_ready  = 1'b0;
                w_state_base = ST_IDLE;
            end
        endcase
        w_legal     = op_is_legal(i_cmd_op);
        w_accept    = i_cmd_valid & w_cmd_ready;
        // Illegal ops skip EXEC and answer directly with an error response.
        w_state_nxt = w_accept ? (w_legal ? ST_EXEC : ST_RESP) : w_state_base;
    end

    // State register plus datapath, response and flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_alu_a      <= {DATA_WIDTH{1'b0}};
            r_alu_b      <= {DATA_WIDTH{1'b0}};
            r_alu_op     <= {ALU_OP_WIDTH{1'b0}};
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= {DATA_WIDTH{1'b0}};
            r_rsp_tag    <= {TAG_WIDTH{1'b0}};
            r_rsp_err    <= 1'b0;
            r_flag_z     <= 1'b0;
            r_flag_n     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept && w_legal) begin
                // ALU inputs only move on a legal accept and hold otherwise.
                r_alu_a   <= i_cmd_a;
                r_alu_b   <= i_cmd_b;
                r_alu_op  <= i_cmd_op;
                r_rsp_tag <= i_cmd_tag;
            end else if (w_accept) begin
                r_rsp_result <= {DATA_WIDTH{1'b0}};
                r_rsp_err    <= 1'b1;
                r_rsp_tag    <= i_cmd_tag;
            end else if (r_state == ST_EXEC) begin
                r_rsp_result <= i_alu_result;
                r_rsp_err    <= 1'b0;
                if (r_alu_op == LP_OP_SUBS) begin
                    r_flag_z <= (i_alu_result == {DATA_WIDTH{1'b0}});
                    r_flag_n <= i_alu_result[DATA_WIDTH-1];
                end
            end
        end
    end

    // No command is taken while reset is being applied.
    assign o_cmd_ready  = w_cmd_ready & ~i_rst;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_op     = r_alu_op;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_tag    = r_rsp_tag;
    assign o_rsp_err    = r_rsp_err;
    assign o_flag_z     = r_flag_z;
    assign o_flag_n     = r_flag_n;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_cmd_issuer. A combinational ALU model closes the loop
// from o_alu_* to i_alu_result. A transaction-level reference (queue of
// expected responses with their latency, tag, result and flags) is checked on
// every falling edge. Directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int DW = 36;
    localparam int OW = 3;
    localparam int TW = 4;

    localparam logic [OW-1:0] OP_ADD  = 3'd0;
    localparam logic [OW-1:0] OP_SUB  = 3'd1;
    localparam logic [OW-1:0] OP_SUBS = 3'd2;
    localparam logic [OW-1:0] OP_AND  = 3'd3;
    localparam logic [OW-1:0] OP_OR   = 3'd4;
    localparam logic [OW-1:0] OP_BAD  = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [OW-1:0] cmd_op;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [TW-1:0] cmd_tag;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic          flag_z;
    logic          flag_n;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_issuer #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW), .TAG_WIDTH(TW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_tag(cmd_tag),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_result),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_tag(rsp_tag), .o_rsp_err(rsp_err),
        .o_flag_z(flag_z), .o_flag_n(flag_n), .o_busy(busy)
    );

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SUBS: return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return '0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [OW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SUBS) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference ----------------
    typedef struct {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
        logic          err;
        logic          z;
        logic          n;
        logic [DW-1:0] aa;
        logic [DW-1:0] ab;
        logic [OW-1:0] aop;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          q[$];
    bit            front_shown = 1'b0;
    logic          m_z, m_n;
    logic [DW-1:0] m_a, m_b;
    logic [OW-1:0] m_op;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            front_shown = 1'b0;
            m_z = 1'b0; m_n = 1'b0;
            m_a = '0; m_b = '0; m_op = '0;
        end else begin
            // cycle-level status of the current front transaction
            chk("busy", busy, (q.size() != 0));
            if (q.size() == 0) begin
                chk("idle_rsp_valid", rsp_valid, 1'b0);
                chk("idle_cmd_ready", cmd_ready, 1'b1);
            end else if (!front_shown) begin
                if (cyc - q[0].acc >= q[0].lat) begin
                    chk("rsp_latency", rsp_valid, 1'b1);
                    front_shown = 1'b1;
                end else begin
                    chk("rsp_valid_early", rsp_valid, 1'b0);
                end
            end else begin
                chk("rsp_valid_held", rsp_valid, 1'b1);
            end
            if (rsp_valid) chk("resp_cmd_ready", cmd_ready, rsp_ready);
            // response handshake
            if (rsp_valid && rsp_ready && q.size() > 0 && front_shown) begin
                chk("m_result", rsp_result, q[0].res);
                chk("m_tag",    rsp_tag,    q[0].tag);
                chk("m_err",    rsp_err,    q[0].err);
                chk("m_flag_z", flag_z,     q[0].z);
                chk("m_flag_n", flag_n,     q[0].n);
                chk("m_alu_a",  alu_a,      q[0].aa);
                chk("m_alu_b",  alu_b,      q[0].ab);
                chk("m_alu_op", alu_op,     q[0].aop);
                void'(q.pop_front());
                front_shown = 1'b0;
            end
            // command accept
            if (cmd_valid && cmd_ready) begin
                e.tag = cmd_tag;
                e.acc = cyc;
                if (is_legal(cmd_op)) begin
                    m_a = cmd_a; m_b = cmd_b; m_op = cmd_op;
                    e.res = alu_f(cmd_op, cmd_a, cmd_b);
                    e.err = 1'b0;
                    e.lat = 2;
                    if (cmd_op == OP_SUBS) begin
                        m_z = (e.res == '0);
                        m_n = e.res[DW-1];
                    end
                end else begin
                    e.res = '0;
                    e.err = 1'b1;
                    e.lat = 1;
                end
                e.z = m_z; e.n = m_n;
                e.aa = m_a; e.ab = m_b; e.aop = m_op;
                q.push_back(e);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] tag);
        bit got = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                last_acc = cyc;
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!got) begin
            errors++; checks++;
            $display("FAIL issue_timeout: tag %0d never accepted", tag);
        end
    endtask

    task automatic expect_rsp(input string name, input int wait_exp,
                              input logic [DW-1:0] res, input logic [TW-1:0] tag,
                              input logic err, input logic z, input logic n);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                chk({name, "_wait"},   i, wait_exp);
                chk({name, "_result"}, rsp_result, res);
                chk({name, "_tag"},    rsp_tag, tag);
                chk({name, "_err"},    rsp_err, err);
                chk({name, "_z"},      flag_z, z);
                chk({name, "_n"},      flag_n, n);
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL %s_timeout: no response", name);
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_tag = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_alu_a", alu_a, 36'h0);
        chk("rst_alu_op", alu_op, 3'd0);
        chk("rst_flags", {flag_z, flag_n}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // basic ADD
        issue(OP_ADD, 36'd5, 36'd7, 4'd3);
        expect_rsp("add", 1, 36'd12, 4'd3, 1'b0, 1'b0, 1'b0);

        // SUBS flag updates, AND keeps flags
        issue(OP_SUBS, 36'd9, 36'd9, 4'd1);
        expect_rsp("subs_eq", 1, 36'd0, 4'd1, 1'b0, 1'b1, 1'b0);
        issue(OP_SUBS, 36'd3, 36'd5, 4'd2);
        expect_rsp("subs_neg", 1, 36'hFFFFFFFFE, 4'd2, 1'b0, 1'b0, 1'b1);
        issue(OP_AND, 36'hF0F, 36'h0FF, 4'd4);
        expect_rsp("and", 1, 36'h00F, 4'd4, 1'b0, 1'b0, 1'b1);

        // backpressure
        rsp_ready = 1'b0;
        issue(OP_OR, 36'h100, 36'h001, 4'd6);
        expect_rsp("or", 1, 36'h101, 4'd6, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 36'd1; cmd_b = 36'd1; cmd_tag = 4'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_result", rsp_result, 36'h101);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        expect_rsp("bp2", 1, 36'd2, 4'd5, 1'b0, 1'b0, 1'b1);

        // illegal opcode
        issue(OP_BAD, 36'h123, 36'h456, 4'd9);
        expect_rsp("ill", 0, 36'd0, 4'd9, 1'b1, 1'b0, 1'b1);
        chk("ill_alu_op", alu_op, OP_ADD);
        chk("ill_alu_a", alu_a, 36'd1);
        chk("ill_alu_b", alu_b, 36'd1);

        // back-to-back with wrap-around
        issue(OP_ADD, 36'd10, 36'd20, 4'd10);
        t0 = last_acc;
        issue(OP_ADD, 36'd7, 36'd8, 4'd11);
        chk("b2b_spacing1", last_acc - t0, 2);
        t0 = last_acc;
        issue(OP_ADD, 36'h800000000, 36'h800000000, 4'd12);
        chk("b2b_spacing2", last_acc - t0, 2);
        t0 = last_acc;
        issue(OP_ADD, 36'hFFFFFFFFF, 36'd1, 4'd13);
        chk("b2b_spacing3", last_acc - t0, 2);
        expect_rsp("wrap", 1, 36'd0, 4'd13, 1'b0, 1'b0, 1'b1);

        // reset during EXEC of SUBS 0-0
        issue(OP_SUBS, 36'd0, 36'd0, 4'd14);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_valid", rsp_valid, 1'b0);
        chk("rst_exec_ready", cmd_ready, 1'b1);
        chk("rst_exec_busy", busy, 1'b0);
        chk("rst_exec_flags", {flag_z, flag_n}, 2'b00);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_exec_no_rsp", rsp_valid, 1'b0);
            @(posedge clk); #1;
        end

        // plain SUB after reset
        issue(OP_SUB, 36'd10, 36'd3, 4'd15);
        expect_rsp("sub", 1, 36'd7, 4'd15, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
